// File: rtl/solver_pkg.sv
// solver_pkg
//   Shared definitions for the SAT solver host sequencer.
//   - CMD_* : command codes understood by the solver core's cmd port.
//   - state_t: sequencer state encoding used by solver_host.
package solver_pkg;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_RESET  = 8'h01;
  localparam logic [7:0] CMD_CLAUSE = 8'h02;
  localparam logic [7:0] CMD_EVAL   = 8'h03;
  localparam logic [7:0] CMD_READ   = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RESET,
    ST_LOAD,
    ST_EVAL,
    ST_WAIT,
    ST_READ,
    ST_CAPT,
    ST_EMIT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/solver_host_timer.sv
// solver_host_timer
//   Wait counter for the evaluate phase. Cleared by i_clr, advances by one
//   on every i_en cycle, and flags o_expired when the count reaches
//   i_lim-1. A limit of zero disables expiry entirely.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_clr       clear the counter to zero (has priority over i_en)
//   i_en        count enable
//   i_lim       wait limit in cycles, 0 = unlimited
//   o_expired   combinational: limit reached in the current cycle
module solver_host_timer #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [TIMEOUT_W-1:0] i_lim,
  output logic                 o_expired
);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  // Count value k is seen during the (k+1)-th wait cycle, so matching
  // lim-1 ends the wait after exactly lim cycles.
  assign o_expired = (i_lim != '0) && (r_cnt == (i_lim - TIMEOUT_W'(1)));

endmodule

// File: rtl/solver_host.sv
// solver_host
//   Host-side command sequencer for the SAT solver core. Collects a clause
//   stream, drives reset / clause-load / evaluate commands, waits for a
//   verdict or a timeout, and on sat reads the assignment bytes back over
//   exbus and emits them on a ready/valid result stream.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a solve (ignored unless idle)
//   timeout_lim              evaluate wait limit in cycles, 0 = none
//   cl_valid/cl_ready        clause stream handshake
//   cl_lit_a/b/c, cl_last    clause literals, final-clause marker
//   cmd, bus_a/b/c           solver command and operands
//   sat, unsat, exbus        solver verdict flags and readback data
//   res_valid/res_ready      result stream handshake
//   res_data, res_idx        assignment byte and its index
//   busy, done               activity level, completion pulse
//   is_sat/is_unsat/timed_out  final status, held until next start
module solver_host
  import solver_pkg::*;
#(
  parameter int STATE_BYTES = 32,
  parameter int TIMEOUT_W   = 24,
  parameter int RST_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  input  logic                 cl_valid,
  output logic                 cl_ready,
  input  logic [7:0]           cl_lit_a,
  input  logic [7:0]           cl_lit_b,
  input  logic [7:0]           cl_lit_c,
  input  logic                 cl_last,
  output logic [7:0]           cmd,
  output logic [7:0]           bus_a,
  output logic [7:0]           bus_b,
  output logic [7:0]           bus_c,
  input  logic                 sat,
  input  logic                 unsat,
  input  logic [7:0]           exbus,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic [7:0]           res_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 is_sat,
  output logic                 is_unsat,
  output logic                 timed_out
);

  localparam int         RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [7:0] LAST_IDX = 8'(STATE_BYTES - 1);

  state_t          r_state;
  logic [RC_W-1:0] r_rst_cnt;
  logic [7:0]      r_idx;
  logic            r_capt_wait;
  logic [7:0]      r_cmd, r_bus_a, r_bus_b, r_bus_c;
  logic            r_cl_ready, r_res_valid;
  logic [7:0]      r_res_data, r_res_idx;
  logic            r_busy, r_done, r_is_sat, r_is_unsat, r_timed_out;
  logic            w_expired;

  solver_host_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_EVAL),
    .i_en      (r_state == ST_WAIT),
    .i_lim     (timeout_lim),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rst_cnt   <= '0;
      r_idx       <= '0;
      r_capt_wait <= 1'b0;
      r_cmd       <= CMD_NOP;
      r_bus_a     <= '0;
      r_bus_b     <= '0;
      r_bus_c     <= '0;
      r_cl_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_is_sat    <= 1'b0;
      r_is_unsat  <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      // Commands are single-cycle strobes; every state that issues one
      // overrides these defaults.
      r_cmd   <= CMD_NOP;
      r_bus_a <= '0;
      r_bus_b <= '0;
      r_bus_c <= '0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_sat    <= 1'b0;
            r_is_unsat  <= 1'b0;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b1;
            r_cmd       <= CMD_RESET;   // first reset cycle appears right away
            r_rst_cnt   <= '0;
            r_state     <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (r_rst_cnt == RC_LAST) begin
            r_cl_ready <= 1'b1;
            r_state    <= ST_LOAD;
          end else begin
            r_cmd     <= CMD_RESET;
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        ST_LOAD: begin
          if (cl_valid && r_cl_ready) begin
            r_cmd   <= CMD_CLAUSE;
            r_bus_a <= cl_lit_a;
            r_bus_b <= cl_lit_b;
            r_bus_c <= cl_lit_c;
            if (cl_last) begin
              r_cl_ready <= 1'b0;
              r_state    <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          r_cmd   <= CMD_EVAL;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Priority: sat, then unsat, then the timeout.
          if (sat) begin
            r_is_sat <= 1'b1;
            r_idx    <= '0;
            r_state  <= ST_READ;
          end else if (unsat) begin
            r_is_unsat <= 1'b1;
            r_state    <= ST_FIN;
          end else if (w_expired) begin
            r_timed_out <= 1'b1;
            r_state     <= ST_FIN;
          end
        end
        ST_READ: begin
          r_cmd       <= CMD_READ;
          r_bus_a     <= r_idx;
          r_capt_wait <= 1'b0;
          r_state     <= ST_CAPT;
        end
        ST_CAPT: begin
          // The first CAPT cycle is the one in which CMD_READ is on the bus;
          // the solver answers on exbus one cycle after that.
          if (!r_capt_wait) begin
            r_capt_wait <= 1'b1;
          end else begin
            r_res_data  <= exbus;
            r_res_idx   <= r_idx;
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_FIN;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_state <= ST_READ;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd       = r_cmd;
  assign bus_a     = r_bus_a;
  assign bus_b     = r_bus_b;
  assign bus_c     = r_bus_c;
  assign cl_ready  = r_cl_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign is_sat    = r_is_sat;
  assign is_unsat  = r_is_unsat;
  assign timed_out = r_timed_out;

endmodule
